// File: rtl/ser_pkg.sv
// Shared serial-link definitions used by both ends of the bit-serial data path.
package ser_pkg;

   typedef logic [1:0] ser_rx_state_t;

   localparam ser_rx_state_t StIdle  = 2'd0;
   localparam ser_rx_state_t StShift = 2'd1;
   localparam ser_rx_state_t StFlush = 2'd2;
   localparam ser_rx_state_t StDone  = 2'd3;

   localparam int unsigned SER_BYTE_BITS  = 8;
   localparam int unsigned SER_WORD_BYTES = 4;

endpackage

// File: rtl/ser_deserializer_if.sv
// Serial input plus RAM write port and frame status of the deserializer.
interface ser_deserializer_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CNT_W  = 16
) ();

   logic              bit_i;
   logic              bit_valid_i;
   logic              ram_wr_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [31:0]       ram_data_o;
   logic              done_o;
   logic [CNT_W-1:0]  byte_cnt_o;
   logic              frame_err_o;
   logic              overrun_o;

   modport master (
      output bit_i, bit_valid_i,
      input  ram_wr_o, ram_addr_o, ram_data_o, done_o, byte_cnt_o, frame_err_o, overrun_o
   );

   modport slave (
      input  bit_i, bit_valid_i,
      output ram_wr_o, ram_addr_o, ram_data_o, done_o, byte_cnt_o, frame_err_o, overrun_o
   );

endinterface

// File: rtl/ser_deserializer.sv
// Serial-to-parallel receiver: MSB-first bytes packed four per word, written to a
// byte-addressed RAM port, with per-frame byte count and partial-byte error.
module ser_deserializer
   import ser_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CNT_W  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   ser_deserializer_if.slave rx
);

   localparam logic [2:0] LastBit  = 3'(SER_BYTE_BITS - 1);
   localparam logic [1:0] LastLane = 2'(SER_WORD_BYTES - 1);

   ser_rx_state_t     state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [6:0]        sh_q, sh_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_data_q, ram_data_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q, overrun_d;
   logic [7:0]        byte_next;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      sh_d        = sh_q;
      byte_idx_d  = byte_idx_q;
      word_d      = word_q;
      addr_d      = addr_q;
      run_cnt_d   = run_cnt_q;
      wr_d        = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_data_d  = ram_data_q;
      done_d      = 1'b0;
      byte_cnt_d  = byte_cnt_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      byte_next   = {sh_q, rx.bit_i};

      case (state_q)
         StIdle: begin
            if (rx.bit_valid_i) begin
               sh_d       = {6'b0, rx.bit_i};
               bit_cnt_d  = 3'd1;
               byte_idx_d = 2'd0;
               word_d     = '0;
               addr_d     = '0;
               ram_addr_d = '0;
               run_cnt_d  = '0;
               state_d    = StShift;
            end
         end
         StShift: begin
            if (rx.bit_valid_i) begin
               sh_d      = byte_next[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LastBit) begin
                  word_d[byte_idx_q*SER_BYTE_BITS +: SER_BYTE_BITS] = byte_next;
                  byte_idx_d = byte_idx_q + 2'd1;
                  if (run_cnt_q != '1) run_cnt_d = run_cnt_q + CNT_W'(1);
                  if (byte_idx_q == LastLane) begin
                     wr_d       = 1'b1;
                     ram_addr_d = addr_q;
                     ram_data_d = word_d;
                     addr_d     = addr_q + ADDR_W'(4);
                     // Start the next word from zeros so a later flush pads unfilled lanes
                     word_d     = '0;
                  end
               end
            end else begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (byte_idx_q != 2'd0) begin
               wr_d       = 1'b1;
               ram_addr_d = addr_q;
               ram_data_d = word_q;
               addr_d     = addr_q + ADDR_W'(4);
            end
            // Status is registered on entry to DONE so it lines up with done_o
            done_d      = 1'b1;
            byte_cnt_d  = run_cnt_q;
            frame_err_d = (bit_cnt_q != 3'd0);
            if (rx.bit_valid_i) overrun_d = 1'b1;
            state_d = StDone;
         end
         StDone: begin
            if (rx.bit_valid_i) overrun_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         sh_q        <= '0;
         byte_idx_q  <= '0;
         word_q      <= '0;
         addr_q      <= '0;
         run_cnt_q   <= '0;
         wr_q        <= 1'b0;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
         done_q      <= 1'b0;
         byte_cnt_q  <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         sh_q        <= sh_d;
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         run_cnt_q   <= run_cnt_d;
         wr_q        <= wr_d;
         ram_addr_q  <= ram_addr_d;
         ram_data_q  <= ram_data_d;
         done_q      <= done_d;
         byte_cnt_q  <= byte_cnt_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx.ram_wr_o    = wr_q;
   assign rx.ram_addr_o  = ram_addr_q;
   assign rx.ram_data_o  = ram_data_q;
   assign rx.done_o      = done_q;
   assign rx.byte_cnt_o  = byte_cnt_q;
   assign rx.frame_err_o = frame_err_q;
   assign rx.overrun_o   = overrun_q;

endmodule

// File: tb/tb_ser_deserializer.sv
// Directed bench for ser_deserializer: logs RAM writes and done pulses, then checks them.
module tb_ser_deserializer;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [15:0] cnt;
      logic        err;
      int          cyc;
   } done_t;

   logic  clk = 1'b0;
   logic  rst_n;
   int    n_tests = 0;
   int    n_fail = 0;
   int    cyc = 0;
   wr_t   wr_q[$];
   done_t dn_q[$];

   always #5 clk = ~clk;

   ser_deserializer_if #(.ADDR_W(10), .CNT_W(16)) rx_if ();

   ser_deserializer #(.ADDR_W(10), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx_if)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_if.ram_wr_o) wr_q.push_back('{rx_if.ram_addr_o, rx_if.ram_data_o, cyc});
      if (rx_if.done_o) dn_q.push_back('{rx_if.byte_cnt_o, rx_if.frame_err_o, cyc});
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [9:0] addr,
                           input logic [31:0] data);
      if (wr_q.size() > idx) begin
         check_eq({tag, "_addr"}, 64'(wr_q[idx].addr), 64'(addr));
         check_eq({tag, "_data"}, 64'(wr_q[idx].data), 64'(data));
      end else begin
         check_eq({tag, "_present"}, 64'(wr_q.size()), 64'(idx + 1));
      end
   endtask

   task automatic check_done(input string tag, input int idx, input logic [15:0] cnt,
                             input logic err);
      if (dn_q.size() > idx) begin
         check_eq({tag, "_cnt"}, 64'(dn_q[idx].cnt), 64'(cnt));
         check_eq({tag, "_err"}, 64'(dn_q[idx].err), 64'(err));
      end else begin
         check_eq({tag, "_present"}, 64'(dn_q.size()), 64'(idx + 1));
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_if.bit_i       = b;
      rx_if.bit_valid_i = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) drive_bit(b[i]);
   endtask

   task automatic end_frame();
      rx_if.bit_valid_i = 1'b0;
      rx_if.bit_i       = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wr_q.delete();
      dn_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      rst_n             = 1'b0;
      rx_if.bit_i       = 1'b1;
      rx_if.bit_valid_i = 1'b1;

      // Reset held with valid high
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_eq("rst_wr", 64'(rx_if.ram_wr_o), 64'd0);
      check_eq("rst_addr", 64'(rx_if.ram_addr_o), 64'd0);
      check_eq("rst_data", 64'(rx_if.ram_data_o), 64'd0);
      check_eq("rst_done", 64'(rx_if.done_o), 64'd0);
      check_eq("rst_cnt", 64'(rx_if.byte_cnt_o), 64'd0);
      check_eq("rst_err", 64'(rx_if.frame_err_o), 64'd0);
      check_eq("rst_ovr", 64'(rx_if.overrun_o), 64'd0);
      check_eq("rst_nwr", 64'(wr_q.size()), 64'd0);
      rx_if.bit_valid_i = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("post_rst_nwr", 64'(wr_q.size()), 64'd0);
      clear_logs();

      // 4-byte frame: one full write, done two cycles later
      send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
      end_frame();
      check_eq("f4_nwr", 64'(wr_q.size()), 64'd1);
      check_wr("f4_w0", 0, 10'h000, 32'hD4C3B2A1);
      check_done("f4_done", 0, 16'd4, 1'b0);
      if (wr_q.size() > 0 && dn_q.size() > 0)
         check_eq("f4_gap", 64'(dn_q[0].cyc - wr_q[0].cyc), 64'd2);
      clear_logs();

      // 6-byte frame: full write then partial write with done
      for (int k = 1; k <= 6; k++) begin
         b = 8'(k);
         send_byte(b);
      end
      end_frame();
      check_eq("f6_nwr", 64'(wr_q.size()), 64'd2);
      check_wr("f6_w0", 0, 10'h000, 32'h04030201);
      check_wr("f6_w1", 1, 10'h004, 32'h00000605);
      check_done("f6_done", 0, 16'd6, 1'b0);
      if (wr_q.size() > 1 && dn_q.size() > 0)
         check_eq("f6_gap", 64'(dn_q[0].cyc - wr_q[1].cyc), 64'd0);
      clear_logs();

      // 13-bit frame: one byte plus partial bits
      send_byte(8'hFF);
      repeat (5) drive_bit(1'b1);
      end_frame();
      check_eq("f13_nwr", 64'(wr_q.size()), 64'd1);
      check_wr("f13_w0", 0, 10'h000, 32'h000000FF);
      check_done("f13_done", 0, 16'd1, 1'b1);
      clear_logs();

      // 1-bit frame: no write, error set
      drive_bit(1'b0);
      end_frame();
      check_eq("f1_nwr", 64'(wr_q.size()), 64'd0);
      check_done("f1_done", 0, 16'd0, 1'b1);
      clear_logs();

      // 260-word frame: address wraps after 0x3FC
      for (int k = 0; k < 1040; k++) begin
         b = 8'(k);
         send_byte(b);
      end
      end_frame();
      check_eq("f260_nwr", 64'(wr_q.size()), 64'd260);
      check_wr("f260_w255", 255, 10'h3FC, 32'hFFFEFDFC);
      check_wr("f260_w256", 256, 10'h000, 32'h03020100);
      check_done("f260_done", 0, 16'd1040, 1'b0);
      clear_logs();

      // Valid dropped one cycle, then bits arrive during FLUSH and DONE
      check_eq("ovr_before", 64'(rx_if.overrun_o), 64'd0);
      send_byte(8'h5A);
      rx_if.bit_valid_i = 1'b0;
      @(posedge clk);
      #1;
      drive_bit(1'b1);
      drive_bit(1'b1);
      send_byte(8'h3C);
      end_frame();
      check_eq("ovr_set", 64'(rx_if.overrun_o), 64'd1);
      check_eq("ovr_nwr", 64'(wr_q.size()), 64'd2);
      check_wr("ovr_w0", 0, 10'h000, 32'h0000005A);
      check_wr("ovr_w1", 1, 10'h000, 32'h0000003C);
      check_done("ovr_d0", 0, 16'd1, 1'b0);
      check_done("ovr_d1", 1, 16'd1, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check_eq("ovr_sticky", 64'(rx_if.overrun_o), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ser_deserializer.md
# ser_deserializer

Serial-to-parallel receiver: the far end of the serial link driven by the bit serializer (`bit_o` / `bit_valid_o`). It samples a qualified bit stream, assembles MSB-first bytes, packs four bytes per 32-bit word, and writes the words into a PL data RAM port with byte addressing. It sits on the capture side of the data path and feeds the same RAM interface style as the pldata RAM (address steps of 4, `{4{wr}}` byte enables driven by the parent).

## Interface
Parameters:
- `ADDR_W`, 10, RAM byte-address width; addresses wrap modulo 2^ADDR_W.
- `CNT_W`, 16, width of the received-byte counter.

Ports:
- `clk`  in  1  single clock; all bits sampled on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_i`  in  1  serial data, MSB of each byte first.
- `bit_valid_i`  in  1  high for every cycle carrying a frame bit; one contiguous high run is one frame.
- `ram_wr_o`  out  1  one-cycle write strobe.
- `ram_addr_o`  out  ADDR_W  byte address of the word; 0 at frame start, +4 after each write.
- `ram_data_o`  out  32  packed word; first byte of the word in [7:0], fourth in [31:24].
- `done_o`  out  1  one-cycle pulse at frame end.
- `byte_cnt_o`  out  CNT_W  complete bytes in the last frame; valid from `done_o`, held until the next `done_o`.
- `frame_err_o`  out  1  the last frame ended on a partial byte; updated with `done_o`.
- `overrun_o`  out  1  sticky; cleared only by reset.

## Operation
- States: IDLE, SHIFT, FLUSH, DONE.
- IDLE: on `bit_valid_i`=1, sample `bit_i` as bit 7 of byte 0. Clear the bit, byte and address counters, and clear the running byte count. Go to SHIFT.
- SHIFT, `bit_valid_i`=1: shift `bit_i` into the byte register. On the 8th bit, place the byte in lane `byte_idx` of the word register, increment the byte count, and advance `byte_idx` (0..3). On the 4th byte, issue a full-word write.
- SHIFT, `bit_valid_i`=0: end of frame. Go to FLUSH.
- FLUSH:
  - If `byte_idx`≠0, write the partial word with unfilled lanes forced to 0.
  - If the bit count is ≠0, discard the partial bits and set the error for this frame.
  - Go to DONE.
- DONE: pulse `done_o`; load `byte_cnt_o` and `frame_err_o`. Go to IDLE.
- `bit_valid_i`=1 during FLUSH or DONE: drop the bit and set `overrun_o`. A frame starts only from IDLE. If valid is still high in IDLE, a new frame starts that cycle.
- Address increments by 4 after every write. It wraps from 2^ADDR_W−4 to 0 silently; there is no overflow flag.
- The byte counter saturates at 2^CNT_W−1.
- Zero-length case: IDLE exits only on a valid bit, so the minimum frame is 1 bit. A 1-bit frame gives `byte_cnt_o`=0, `frame_err_o`=1, no write.

## Timing
- Reset values: `ram_wr_o`=0, `ram_addr_o`=0, `ram_data_o`=0, `done_o`=0, `byte_cnt_o`=0, `frame_err_o`=0, `overrun_o`=0, state IDLE.
- All outputs are registered.
- Full-word write: `ram_wr_o`=1 in the cycle after the 32nd bit of the word is sampled. `ram_addr_o` and `ram_data_o` are valid in that same cycle.
- Frame end, with cycle c0 = last valid bit and c1 = first cycle with valid=0:
  - c1: state SHIFT (a full-word write from c0 appears here).
  - c2: FLUSH; a partial write appears in c3.
  - c3: DONE; `done_o`=1.
  - c4: IDLE.
- Restated against `done_o`: a partial-word write occurs in the same cycle as `done_o`. A full-word write completed by the last bit precedes `done_o` by two cycles.
- Back-to-back writes are possible every 32 cycles; no write collision exists.
- Asynchronous reset mid-frame aborts immediately:
  - no flush and no `done_o`;
  - RAM contents already written are left untouched.

## Structure
- Shared package `ser_pkg`:
  - state encoding `ser_rx_state_t`;
  - constants `SER_BYTE_BITS`=8 and `SER_WORD_BYTES`=4 (shared with the serializer).
- Single module; no sub-module needed.
- Byte-lane packing is an inline indexed assignment.

## Test plan
- Reset with `bit_valid_i`=1 held: all outputs 0, no writes until `rst_n` rises.
- 4-byte frame 0xA1,0xB2,0xC3,0xD4 (32 valid cycles): one write, addr 0, data 0xD4C3B2A1. `done_o` comes 2 cycles after the write; `byte_cnt_o`=4, `frame_err_o`=0.
- 6-byte frame 0x01..0x06: two writes.
  - Write 1: addr 0, data 0x04030201.
  - Write 2: addr 4, data 0x00000605, same cycle as `done_o`.
  - `byte_cnt_o`=6.
- 13-bit frame starting 0xFF then 5 ones: one write, addr 0, data 0x000000FF. `byte_cnt_o`=1, `frame_err_o`=1.
- 260-word frame with `ADDR_W`=10: write 256 goes to addr 0x3FC, write 257 to addr 0x000. `byte_cnt_o`=1040.
- Valid dropped for 1 cycle then re-raised:
  - First frame completes with `done_o`.
  - Valid bits during FLUSH/DONE set `overrun_o`=1, which stays 1.
  - The next frame restarts at addr 0.
